// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN accelerator: top-level FSM state encoding,
// image geometry and the byte packing used by the pixel loader.
package bnn_pkg;

  typedef enum logic [2:0] {
    s_IDLE    = 3'b000,
    s_LOAD    = 3'b001,
    s_LAYER_1 = 3'b010,
    s_LAYER_2 = 3'b011,
    s_LAYER_3 = 3'b100
  } state_t;

  localparam int IMG_DIM    = 28;
  localparam int NUM_PIXELS = 784;
  localparam int BYTE_W     = 8;

  // Derived from the pixel count; these are not meant to be overridden.
  localparam int NUM_BYTES = (NUM_PIXELS + BYTE_W - 1) / BYTE_W;
  localparam int ADDR_W    = $clog2(NUM_BYTES);
  localparam int LAST_BITS = NUM_PIXELS - (NUM_BYTES - 1) * BYTE_W;
  localparam logic [BYTE_W-1:0] LAST_MASK = BYTE_W'((1 << LAST_BITS) - 1);

  // Pixels past the end of the image in the final byte must read as zero.
  function automatic logic [BYTE_W-1:0] byte_mask(input logic [ADDR_W-1:0] addr);
    byte_mask = '1;
    if (addr == ADDR_W'(NUM_BYTES - 1)) begin
      byte_mask = LAST_MASK;
    end
  endfunction

endpackage

// File: rtl/pixel_loader_if.sv
// Pin-side byte input and image-buffer write port of the pixel loader.
interface pixel_loader_if;
  import bnn_pkg::*;

  logic [BYTE_W-1:0] pix_data;
  logic              pix_strobe;
  logic              pix_ready;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [BYTE_W-1:0] buf_wdata;
  logic              load_done;

  // The loader itself.
  modport master (
    input  pix_data, pix_strobe,
    output pix_ready, buf_we, buf_addr, buf_wdata, load_done
  );

  // The pins, buffer and FSM that surround the loader.
  modport slave (
    output pix_data, pix_strobe,
    input  pix_ready, buf_we, buf_addr, buf_wdata, load_done
  );

endinterface

// File: rtl/pixel_loader_sync.sv
// Two-flop synchroniser for an asynchronous strobe plus its data bus, with a
// history flop on the strobe so a rising edge yields a single-cycle pulse.
module sync_edge_det #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         strobe_in,
  input  logic [W-1:0] data_in,
  output logic         edge_o,
  output logic [W-1:0] data_o
);

  logic         s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [W-1:0] d1_q, d1_d, d2_q, d2_d;

  // Shift strobe and data through equal depth so data is aligned with s2.
  always_comb begin
    s1_d = strobe_in;
    s2_d = s1_q;
    s3_d = s2_q;
    d1_d = data_in;
    d2_d = d1_q;
  end

  // Synchroniser registers; reset discards anything already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
    end
  end

  assign edge_o = s2_q & ~s3_q;
  assign data_o = d2_q;

endmodule

// File: rtl/pixel_loader.sv
// Loads one packed binary MNIST image into the image buffer while the top
// FSM sits in s_LOAD, then raises load_done until the FSM moves on.
module pixel_loader
  import bnn_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  state_t         state,
  pixel_loader_if.master bus
);

  localparam logic [1:0] L_WAIT = 2'd0;
  localparam logic [1:0] L_RECV = 2'd1;
  localparam logic [1:0] L_DONE = 2'd2;

  logic [1:0]        l_state_q, l_state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              pix_ready_q, pix_ready_d;
  logic              buf_we_q, buf_we_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [BYTE_W-1:0] buf_wdata_q, buf_wdata_d;
  logic              load_done_q, load_done_d;

  logic              pix_edge;
  logic [BYTE_W-1:0] pix_sync;

  sync_edge_det #(.W(BYTE_W)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .strobe_in (bus.pix_strobe),
    .data_in   (bus.pix_data),
    .edge_o    (pix_edge),
    .data_o    (pix_sync)
  );

  // Receive sequencing: wait for s_LOAD, write one byte per strobe edge,
  // finish on the last address and abort cleanly if s_LOAD is left early.
  always_comb begin
    l_state_d   = l_state_q;
    cnt_d       = cnt_q;
    buf_we_d    = 1'b0;
    buf_addr_d  = buf_addr_q;
    buf_wdata_d = buf_wdata_q;
    load_done_d = load_done_q;
    case (l_state_q)
      L_WAIT: begin
        cnt_d       = '0;
        load_done_d = 1'b0;
        if (state == s_LOAD) begin
          l_state_d = L_RECV;
        end
      end
      L_RECV: begin
        if (state != s_LOAD) begin
          l_state_d = L_WAIT;
          cnt_d     = '0;
        end else if (pix_edge) begin
          buf_we_d    = 1'b1;
          buf_addr_d  = cnt_q;
          buf_wdata_d = pix_sync & byte_mask(cnt_q);
          cnt_d       = cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(NUM_BYTES - 1)) begin
            l_state_d   = L_DONE;
            load_done_d = 1'b1;
          end
        end
      end
      L_DONE: begin
        load_done_d = 1'b1;
        if (state != s_LOAD) begin
          l_state_d   = L_WAIT;
          load_done_d = 1'b0;
        end
      end
      default: begin
        l_state_d = L_WAIT;
      end
    endcase
    pix_ready_d = (l_state_d == L_RECV);
  end

  // State and registered outputs, all cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_state_q   <= L_WAIT;
      cnt_q       <= '0;
      pix_ready_q <= 1'b0;
      buf_we_q    <= 1'b0;
      buf_addr_q  <= '0;
      buf_wdata_q <= '0;
      load_done_q <= 1'b0;
    end else begin
      l_state_q   <= l_state_d;
      cnt_q       <= cnt_d;
      pix_ready_q <= pix_ready_d;
      buf_we_q    <= buf_we_d;
      buf_addr_q  <= buf_addr_d;
      buf_wdata_q <= buf_wdata_d;
      load_done_q <= load_done_d;
    end
  end

  assign bus.pix_ready = pix_ready_q;
  assign bus.buf_we    = buf_we_q;
  assign bus.buf_addr  = buf_addr_q;
  assign bus.buf_wdata = buf_wdata_q;
  assign bus.load_done = load_done_q;

endmodule

// File: tb/tb_pixel_loader.sv
// Self-checking bench for pixel_loader: directed vector table plus
// hand-written sequences for full loads, overflow, abort and reset.
module tb_pixel_loader;
  import bnn_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t state;
  int     checks = 0;
  int     errors = 0;

  pixel_loader_if bus ();

  pixel_loader dut (
    .clk   (clk),
    .rst   (rst),
    .state (state),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [BYTE_W-1:0] wr_data_q[$];
  logic              wr_done_q[$];

  // Record every buffer write together with load_done at that cycle.
  always @(negedge clk) begin
    if (bus.buf_we === 1'b1) begin
      wr_addr_q.push_back(bus.buf_addr);
      wr_data_q.push_back(bus.buf_wdata);
      wr_done_q.push_back(bus.load_done);
    end
  end

  typedef struct {
    state_t st;
    int     n_bytes;
    int     hold;
    int     exp_writes;
    int     exp_done;
    int     exp_first_addr;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic clearLog();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_done_q.delete();
  endtask

  // One byte on the pins: data first, strobe high for 'hold' cycles, then a gap.
  task automatic applyStimulus(input logic [BYTE_W-1:0] val, input int hold);
    @(negedge clk);
    bus.pix_data = val;
    @(negedge clk);
    bus.pix_strobe = 1'b1;
    repeat (hold) @(negedge clk);
    bus.pix_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic sendBytes(input int n, input int hold);
    for (int i = 0; i < n; i++) begin
      applyStimulus(8'(i) ^ 8'hA5, hold);
    end
  endtask

  // Logged writes must be addresses 0,1,2.. carrying byte n = n ^ 8'hA5.
  task automatic checkSequence(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] !== ADDR_W'(i)) bad++;
      if (wr_data_q[i] !== (8'(i) ^ 8'hA5)) bad++;
    end
    checkOutput(name, bad, 0);
  endtask

  function automatic int lastDone();
    lastDone = (wr_done_q.size() > 0) ? int'(wr_done_q[wr_done_q.size()-1]) : -1;
  endfunction

  function automatic int prevDone();
    prevDone = (wr_done_q.size() > 1) ? int'(wr_done_q[wr_done_q.size()-2]) : -1;
  endfunction

  initial begin
    vecs[0] = '{st: s_IDLE,    n_bytes: 3, hold: 2,  exp_writes: 0, exp_done: 0, exp_first_addr: 0};
    vecs[1] = '{st: s_LAYER_2, n_bytes: 3, hold: 2,  exp_writes: 0, exp_done: 0, exp_first_addr: 0};
    vecs[2] = '{st: s_LAYER_3, n_bytes: 2, hold: 2,  exp_writes: 0, exp_done: 0, exp_first_addr: 0};
    vecs[3] = '{st: s_LOAD,    n_bytes: 1, hold: 20, exp_writes: 1, exp_done: 0, exp_first_addr: 0};
    vecs[4] = '{st: s_LOAD,    n_bytes: 5, hold: 2,  exp_writes: 5, exp_done: 0, exp_first_addr: 0};

    rst            = 1'b1;
    state          = s_LOAD;
    bus.pix_data   = '0;
    bus.pix_strobe = 1'b0;

    // Reset held with s_LOAD and a toggling strobe: everything stays at zero.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.pix_strobe = ~bus.pix_strobe;
      checkOutput("reset_outputs",
                  int'({bus.pix_ready, bus.buf_we, bus.buf_addr, bus.buf_wdata, bus.load_done}), 0);
    end
    rst            = 1'b0;
    bus.pix_strobe = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("ready_after_reset", int'(bus.pix_ready), 1);

    // Full image.
    clearLog();
    sendBytes(NUM_BYTES, 2);
    checkOutput("full_write_count", wr_addr_q.size(), NUM_BYTES);
    checkSequence("full_addr_data");
    checkOutput("full_done_with_last", lastDone(), 1);
    checkOutput("full_done_before_last", prevDone(), 0);
    checkOutput("full_done_level", int'(bus.load_done), 1);
    checkOutput("full_ready_low", int'(bus.pix_ready), 0);
    state = s_LAYER_1;
    repeat (2) @(negedge clk);
    checkOutput("done_clear_layer1", int'(bus.load_done), 0);
    state = s_IDLE;
    repeat (3) @(negedge clk);

    // Vector table: ignored states, held strobe, partial loads.
    for (int v = 0; v < 5; v++) begin
      clearLog();
      state = vecs[v].st;
      repeat (3) @(negedge clk);
      sendBytes(vecs[v].n_bytes, vecs[v].hold);
      checkOutput($sformatf("vec%0d_writes", v), wr_addr_q.size(), vecs[v].exp_writes);
      checkOutput($sformatf("vec%0d_done", v), int'(bus.load_done), vecs[v].exp_done);
      if (vecs[v].exp_writes > 0 && wr_addr_q.size() > 0) begin
        checkOutput($sformatf("vec%0d_first_addr", v), int'(wr_addr_q[0]), vecs[v].exp_first_addr);
        checkOutput($sformatf("vec%0d_first_data", v), int'(wr_data_q[0]), 'hA5);
      end
      state = s_IDLE;
      repeat (3) @(negedge clk);
    end

    // Overflow: 100 bytes give only 98 writes, load_done holds until state moves.
    clearLog();
    state = s_LOAD;
    repeat (3) @(negedge clk);
    sendBytes(NUM_BYTES + 2, 2);
    checkOutput("ovf_write_count", wr_addr_q.size(), NUM_BYTES);
    checkSequence("ovf_addr_data");
    repeat (10) @(negedge clk);
    checkOutput("ovf_done_held", int'(bus.load_done), 1);
    state = s_IDLE;
    repeat (2) @(negedge clk);
    checkOutput("ovf_done_clear", int'(bus.load_done), 0);
    repeat (2) @(negedge clk);

    // Abort after 40 bytes, then a fresh s_LOAD restarts at address 0.
    clearLog();
    state = s_LOAD;
    repeat (3) @(negedge clk);
    sendBytes(40, 2);
    checkOutput("abort_writes", wr_addr_q.size(), 40);
    state = s_IDLE;
    repeat (3) @(negedge clk);
    checkOutput("abort_done_low", int'(bus.load_done), 0);
    state = s_LOAD;
    repeat (3) @(negedge clk);
    clearLog();
    sendBytes(NUM_BYTES - 1, 2);
    checkOutput("restart_writes_97", wr_addr_q.size(), NUM_BYTES - 1);
    checkOutput("restart_done_not_yet", int'(bus.load_done), 0);
    applyStimulus(8'(NUM_BYTES - 1) ^ 8'hA5, 2);
    checkOutput("restart_writes_98", wr_addr_q.size(), NUM_BYTES);
    checkSequence("restart_addr_data");
    checkOutput("restart_done", int'(bus.load_done), 1);
    state = s_IDLE;
    repeat (3) @(negedge clk);

    // Reset two cycles after a strobe rise discards the byte in flight.
    clearLog();
    state = s_LOAD;
    repeat (3) @(negedge clk);
    bus.pix_data = 8'h3C;
    @(negedge clk);
    bus.pix_strobe = 1'b1;
    repeat (2) @(negedge clk);
    rst            = 1'b1;
    bus.pix_strobe = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_we", int'(bus.buf_we), 0);
    checkOutput("rst_mid_addr", int'(bus.buf_addr), 0);
    checkOutput("rst_mid_outputs",
                int'({bus.pix_ready, bus.buf_we, bus.buf_addr, bus.buf_wdata, bus.load_done}), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rst_mid_no_write", wr_addr_q.size(), 0);
    sendBytes(NUM_BYTES, 2);
    checkOutput("post_rst_writes", wr_addr_q.size(), NUM_BYTES);
    checkSequence("post_rst_addr_data");
    checkOutput("post_rst_done", int'(bus.load_done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_loader.md
Name: pixel_loader

Overview:
- Responder to the top-level sequencing FSM's s_LOAD state. Produces the load_done handshake that the FSM waits on.
- While the FSM is in s_LOAD, it receives the binarised 28x28 MNIST image off-chip as packed bytes and writes them into the image buffer. The strobe and data inputs are asynchronous.
- Asserts load_done once the full image is stored.

Parameters:
- NUM_PIXELS, 784, binary pixels per image.
- BYTE_W, 8, pixels per transfer byte.
- NUM_BYTES, ceil(NUM_PIXELS/BYTE_W) = 98, derived; not overridable.
- ADDR_W, $clog2(NUM_BYTES) = 7, derived buffer address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- state  in  3  FSM state, encoding from the shared package (s_LOAD = 3'b001).
- pix_data  in  BYTE_W  packed pixels from pins; bit i = pixel (8*addr+i). Asynchronous.
- pix_strobe  in  1  from pins; a rising edge marks pix_data valid. Asynchronous.
- pix_ready  out  1  registered; high = loader accepting bytes.
- buf_we  out  1  one-cycle write enable to the image buffer.
- buf_addr  out  ADDR_W  byte address, 0..NUM_BYTES-1.
- buf_wdata  out  BYTE_W  byte to write.
- load_done  out  1  level; tells the FSM the image is complete.

Behaviour:
- Reset: all outputs 0. Synchroniser flops, byte counter and internal state cleared. Internal state goes to L_WAIT.
- Input synchroniser:
  - pix_strobe passes through 2 flops (s1, s2) plus a history flop s3. edge = s2 & ~s3.
  - pix_data passes through the same 2-flop depth, so the data sample is aligned with s2.
  - The external source holds pix_data stable from ≥1 cycle before the strobe rise until the strobe falls.
- Internal FSM: L_WAIT, L_RECV, L_DONE.
  - L_WAIT: pix_ready=0. Go to L_RECV when state==s_LOAD. Clear the counter on entry.
  - L_RECV: pix_ready=1. On an edge, register buf_we=1 with buf_addr=cnt and buf_wdata=synced data, then cnt++. When the write with cnt==NUM_BYTES-1 issues, go to L_DONE on the same edge.
  - L_DONE: pix_ready=0 and load_done=1. Hold until state!=s_LOAD, then clear load_done and go to L_WAIT.
- Latency:
  - Strobe first sampled high at posedge k gives edge true after k+1, and buf_we high for the single cycle after posedge k+2.
  - load_done rises on the same posedge as the final buf_we, so the FSM sees it at the following posedge.
- Last byte: if NUM_PIXELS is not a multiple of BYTE_W, the unused upper bits of the last byte are forced to 0.
- Edges while state!=s_LOAD, or in L_DONE, are ignored. They cause no write and no counter change.
- Bytes beyond NUM_BYTES are ignored. The counter never wraps.
- If state leaves s_LOAD while in L_RECV: abort to L_WAIT, clear the counter, issue no write, keep load_done=0. Bytes already written stay in the buffer.
- Strobe held high continuously produces exactly one write.
- A strobe rising in the same cycle the FSM enters s_LOAD is accepted, because L_WAIT→L_RECV does not gate the synchroniser.
- rst mid-transfer: the next cycle has all outputs 0 and the counter at 0. A strobe already in flight in the synchroniser is discarded.
- A new image needs a fresh s_LOAD visit. Re-entering s_LOAD restarts at address 0.

Decomposition:
- Shared package (bnn_pkg): the state_t enum (s_IDLE..s_LAYER_3, 3 bits), NUM_PIXELS, IMG_DIM=28 and BYTE_W.
- The fsm and the layer blocks import the same package.
- One sub-module: sync_edge_det. It holds the 2-flop synchroniser plus rising-edge detect, parameterised on data width, and carries strobe and data together.

Test Plan:
- Reset with state=s_LOAD and strobe toggling → all outputs 0 for the whole reset. After release, pix_ready=1 within 2 cycles.
- state=s_LOAD, send 98 bytes with byte n = n^8'hA5:
  - buf_we pulses exactly 98 times, with addresses 0..97 in order and data matching.
  - load_done rises with the final write. FSM model moves to s_LAYER_1.
- Strobe pulses while state=s_IDLE, then while s_LAYER_2 → zero buf_we, load_done stays 0.
- Strobe held high for 20 cycles → exactly one write.
- Then send 100 bytes in s_LOAD → 98 writes only, and load_done stays 1 until state changes.
- 40 bytes sent, then state forced to s_IDLE, then s_LOAD again → counter restarts. Next write is at address 0 and load_done only follows 98 further bytes.
- rst asserted 2 cycles after a strobe rise → no write for that byte, buf_addr=0. Completing a full 98-byte load afterwards passes.
